fetch_sequencer: RTL and testbench

Instruction-fetch and program-counter sequencer for the 8-bit accumulator-style core. It owns the PC, requests instructions from instruction memory over a req/ack handshake, and presents each instruction to the instruction decoder for one cycle. It then applies the decoder's branch-forward, branch-backward and done responses, inserting a one-cycle flush bubble after taken branches. It also tracks retired-instruction count and the halt state.

---
 rtl/fetch_sequencer_if.sv | 43 ++++
 rtl/fetch_sequencer.sv | 153 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: groups the instruction-memory handshake, decoder
// handshake and status signals of the fetch sequencer into one bundle.
// master = the sequencer itself, slave = the surrounding core/memory.
interface fetch_sequencer_if #(
  parameter int PC_W     = 10,
  parameter int OFFSET_W = 8
);
  // control
  logic                start_i;
  logic [PC_W-1:0]     start_addr_i;
  // instruction memory
  logic                imem_req_o;
  logic [PC_W-1:0]     imem_addr_o;
  logic                imem_ack_i;
  logic [7:0]          imem_data_i;
  // decoder
  logic [7:0]          instr_o;
  logic                instr_valid_o;
  logic                branchf_i;
  logic                branchb_i;
  logic                done_i;
  logic [OFFSET_W-1:0] offset_i;
  logic                flush_o;
  // status
  logic [PC_W-1:0]     pc_o;
  logic                halted_o;
  logic                fault_o;
  logic [15:0]         instr_count_o;

  modport master (
    input  start_i, start_addr_i, imem_ack_i, imem_data_i,
           branchf_i, branchb_i, done_i, offset_i,
    output imem_req_o, imem_addr_o, instr_o, instr_valid_o, flush_o,
           pc_o, halted_o, fault_o, instr_count_o
  );

  modport slave (
    output start_i, start_addr_i, imem_ack_i, imem_data_i,
           branchf_i, branchb_i, done_i, offset_i,
    input  imem_req_o, imem_addr_o, instr_o, instr_valid_o, flush_o,
           pc_o, halted_o, fault_o, instr_count_o
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches one instruction at a time over a
// req/ack handshake, presents it to the decoder for one EXEC cycle and then
// applies the decoder's done / forward-branch / backward-branch response.
// Taken branches insert a single FLUSH bubble. Retired instructions are
// counted with a saturating 16-bit counter.
// Optional feature: define FETCH_TIMEOUT_EN to add a fetch watchdog that
// halts with fault_o=1 after TIMEOUT_CYCLES FETCH cycles without ack.
module fetch_sequencer #(
  parameter int PC_W           = 10,
  parameter int OFFSET_W       = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               clk_i,
  input logic               reset_n_i,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_FLUSH,
    ST_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      instr_q, instr_d;
  logic            halted_q, halted_d;
  logic [15:0]     count_q, count_d;
  logic [PC_W-1:0] offset_ext;

  // Offsets are unsigned magnitudes; PC arithmetic wraps modulo 2^PC_W.
  assign offset_ext = PC_W'(bus.offset_i);

`ifdef FETCH_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              fault_q, fault_d;
`endif

  // State register; reset wins over any fetch in flight.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state and next-datapath decode; hold everything by default.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    halted_d = halted_q;
    count_d  = count_q;
`ifdef FETCH_TIMEOUT_EN
    fault_d  = fault_q;
    wait_d   = wait_q;
`endif
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.start_i) begin
          pc_d     = bus.start_addr_i;
          count_d  = '0;
          halted_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          fault_d  = 1'b0;
`endif
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.imem_ack_i) begin
          instr_d = bus.imem_data_i;
          state_d = ST_EXEC;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          halted_d = 1'b1;
          fault_d  = 1'b1;
          state_d  = ST_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
`endif
      end
      ST_EXEC: begin
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        if (bus.done_i) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (bus.branchf_i) begin
          pc_d    = pc_q + offset_ext;
          state_d = ST_FLUSH;
        end else if (bus.branchb_i) begin
          pc_d    = pc_q - offset_ext;
          state_d = ST_FLUSH;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_FETCH;
        end
      end
      ST_FLUSH: begin
        state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifdef FETCH_TIMEOUT_EN
    // Keeping the counter at zero outside FETCH clears it on every entry.
    if (state_q != ST_FETCH) wait_d = '0;
`endif
  end

  // Registered datapath and status outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pc_q     <= '0;
      instr_q  <= '0;
      halted_q <= 1'b0;
      count_q  <= '0;
`ifdef FETCH_TIMEOUT_EN
      fault_q  <= 1'b0;
      wait_q   <= '0;
`endif
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      halted_q <= halted_d;
      count_q  <= count_d;
`ifdef FETCH_TIMEOUT_EN
      fault_q  <= fault_d;
      wait_q   <= wait_d;
`endif
    end
  end

  // Handshake strobes depend on the state register only.
  assign bus.imem_req_o    = (state_q == ST_FETCH);
  assign bus.imem_addr_o   = pc_q;
  assign bus.instr_valid_o = (state_q == ST_EXEC);
  assign bus.flush_o       = (state_q == ST_FLUSH);
  assign bus.instr_o       = instr_q;
  assign bus.pc_o          = pc_q;
  assign bus.halted_o      = halted_q;
  assign bus.instr_count_o = count_q;
`ifdef FETCH_TIMEOUT_EN
  assign bus.fault_o       = fault_q;
`else
  assign bus.fault_o       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks with literal expectations followed by
// randomized stimulus, all compared every cycle against a behavioural model
// of the fetch sequencer kept in this bench.
module tb_fetch_sequencer;
  localparam int PC_W    = 10;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic cmp_en = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  fetch_sequencer_if #(.PC_W(PC_W), .OFFSET_W(8)) bus ();

  fetch_sequencer #(.PC_W(PC_W), .OFFSET_W(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase of the instruction life cycle plus plain ints.
  typedef enum {P_IDLE, P_FETCH, P_EXEC, P_FLUSH, P_HALT} phase_e;
  phase_e m_phase;
  int     m_pc, m_instr, m_count, m_wait;
  bit     m_halted, m_fault;

  // Advance the model on each rising edge from the inputs present then.
  always @(posedge clk) begin
    if (!reset_n) begin
      m_phase <= P_IDLE; m_pc <= 0; m_instr <= 0; m_count <= 0;
      m_halted <= 1'b0; m_fault <= 1'b0; m_wait <= 0;
    end else begin
      case (m_phase)
        P_IDLE, P_HALT:
          if (bus.start_i) begin
            m_pc <= int'(bus.start_addr_i); m_count <= 0;
            m_halted <= 1'b0; m_fault <= 1'b0; m_wait <= 0;
            m_phase <= P_FETCH;
          end
        P_FETCH:
          if (bus.imem_ack_i) begin
            m_instr <= int'(bus.imem_data_i);
            m_phase <= P_EXEC;
          end else begin
`ifdef FETCH_TIMEOUT_EN
            if (m_wait + 1 >= TIMEOUT) begin
              m_halted <= 1'b1; m_fault <= 1'b1; m_phase <= P_HALT;
            end
`endif
            m_wait <= m_wait + 1;
          end
        P_EXEC: begin
          m_count <= (m_count < 65535) ? m_count + 1 : 65535;
          m_wait  <= 0;
          if (bus.done_i) begin
            m_halted <= 1'b1; m_phase <= P_HALT;
          end else if (bus.branchf_i) begin
            m_pc <= (m_pc + int'(bus.offset_i)) % PC_MOD; m_phase <= P_FLUSH;
          end else if (bus.branchb_i) begin
            m_pc <= (m_pc - int'(bus.offset_i) + PC_MOD) % PC_MOD; m_phase <= P_FLUSH;
          end else begin
            m_pc <= (m_pc + 1) % PC_MOD; m_phase <= P_FETCH;
          end
        end
        P_FLUSH: begin
          m_wait <= 0; m_phase <= P_FETCH;
        end
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic [9:0] sa, input logic ack,
                               input logic [7:0] data, input logic bf, input logic bb,
                               input logic dn, input logic [7:0] off);
    bus.start_i = st; bus.start_addr_i = sa; bus.imem_ack_i = ack; bus.imem_data_i = data;
    bus.branchf_i = bf; bus.branchb_i = bb; bus.done_i = dn; bus.offset_i = off;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("m_req",    32'(bus.imem_req_o),    32'(m_phase == P_FETCH));
      if (m_phase == P_FETCH) checkOutput("m_addr", 32'(bus.imem_addr_o), 32'(m_pc));
      checkOutput("m_valid",  32'(bus.instr_valid_o), 32'(m_phase == P_EXEC));
      checkOutput("m_flush",  32'(bus.flush_o),       32'(m_phase == P_FLUSH));
      checkOutput("m_instr",  32'(bus.instr_o),       32'(m_instr));
      checkOutput("m_pc",     32'(bus.pc_o),          32'(m_pc));
      checkOutput("m_halted", 32'(bus.halted_o),      32'(m_halted));
      checkOutput("m_fault",  32'(bus.fault_o),       32'(m_fault));
      checkOutput("m_count",  32'(bus.instr_count_o), 32'(m_count));
    end
  end

  // Directed scenarios with literal expectations, then random traffic.
  initial begin
    int fetch_cycles;
    reset_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    cmp_en = 1'b1;
    checkOutput("rst_req", 32'(bus.imem_req_o), 0);
    checkOutput("rst_pc", 32'(bus.pc_o), 0);
    checkOutput("rst_count", 32'(bus.instr_count_o), 0);
    checkOutput("rst_halted", 32'(bus.halted_o), 0);

    // Sequential fetch with immediate ack.
    reset_n = 1'b1;
    applyStimulus(1, 10'h010, 1, 8'hA1, 0, 0, 0, 0);
    step();
    applyStimulus(0, 10'h010, 1, 8'hA1, 0, 0, 0, 0);
    checkOutput("seq_req", 32'(bus.imem_req_o), 1);
    checkOutput("seq_addr0", 32'(bus.imem_addr_o), 32'h010);
    step();
    checkOutput("seq_valid", 32'(bus.instr_valid_o), 1);
    checkOutput("seq_instr", 32'(bus.instr_o), 32'hA1);
    step();
    checkOutput("seq_addr1", 32'(bus.imem_addr_o), 32'h011);
    step(); step();
    checkOutput("seq_addr2", 32'(bus.imem_addr_o), 32'h012);
    step(); step();
    checkOutput("seq_count3", 32'(bus.instr_count_o), 3);

    // All decoder responses at once: done has priority.
    step();
    applyStimulus(0, 0, 1, 8'hA1, 1, 1, 1, 8'h07);
    step();
    checkOutput("prio_halted", 32'(bus.halted_o), 1);
    checkOutput("prio_pc", 32'(bus.pc_o), 32'h013);
    checkOutput("prio_req", 32'(bus.imem_req_o), 0);

    // Restart at 0x020, forward branch by 5.
    applyStimulus(1, 10'h020, 1, 8'hB2, 0, 0, 0, 0);
    step();
    checkOutput("rs_addr", 32'(bus.imem_addr_o), 32'h020);
    checkOutput("rs_halted", 32'(bus.halted_o), 0);
    checkOutput("rs_count", 32'(bus.instr_count_o), 0);
    applyStimulus(0, 0, 1, 8'hB2, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 1, 8'hB3, 1, 0, 0, 8'd5);
    step();
    checkOutput("bf_flush", 32'(bus.flush_o), 1);
    checkOutput("bf_valid", 32'(bus.instr_valid_o), 0);
    applyStimulus(0, 0, 1, 8'hB3, 0, 0, 0, 0);
    step();
    checkOutput("bf_flush_off", 32'(bus.flush_o), 0);
    checkOutput("bf_target", 32'(bus.imem_addr_o), 32'h025);

    // Both branch flags: forward wins.
    step();
    applyStimulus(0, 0, 1, 8'hB3, 1, 1, 0, 8'd3);
    step();
    applyStimulus(0, 0, 1, 8'hB3, 0, 0, 0, 0);
    step();
    checkOutput("both_target", 32'(bus.imem_addr_o), 32'h028);

    // Backward branch wraps below zero: 0x010 - 0x30 = 0x3E0.
    step();
    applyStimulus(0, 0, 1, 8'hB3, 0, 0, 1, 0);
    step();
    applyStimulus(1, 10'h010, 1, 8'hB3, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 1, 8'hB3, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 1, 8'hB3, 0, 1, 0, 8'h30);
    step();
    applyStimulus(0, 0, 0, 8'h5C, 0, 0, 0, 0);
    step();
    checkOutput("bb_wrap", 32'(bus.imem_addr_o), 32'h3E0);

    // Ack delayed 4 cycles; start pulses mid-fetch are ignored.
    checkOutput("dly_req0", 32'(bus.imem_req_o), 1);
    for (int i = 1; i <= 4; i++) begin
      step();
      checkOutput("dly_req", 32'(bus.imem_req_o), 1);
      checkOutput("dly_addr", 32'(bus.imem_addr_o), 32'h3E0);
      if (i == 2) begin bus.start_i = 1'b1; bus.start_addr_i = 10'h100; end
      if (i == 3) bus.start_i = 1'b0;
      if (i == 4) bus.imem_ack_i = 1'b1;
    end
    step();
    checkOutput("dly_valid", 32'(bus.instr_valid_o), 1);
    checkOutput("dly_instr", 32'(bus.instr_o), 32'h5C);
    checkOutput("dly_pc", 32'(bus.pc_o), 32'h3E0);
    applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 0);
    step();
    checkOutput("rf_addr", 32'(bus.imem_addr_o), 32'h3E1);

    // Reset during a pending fetch.
    reset_n = 1'b0;
    step();
    checkOutput("rf_req", 32'(bus.imem_req_o), 0);
    checkOutput("rf_pc", 32'(bus.pc_o), 0);
    checkOutput("rf_instr", 32'(bus.instr_o), 0);
    checkOutput("rf_count", 32'(bus.instr_count_o), 0);
    reset_n = 1'b1;

`ifdef FETCH_TIMEOUT_EN
    // Watchdog: no ack for TIMEOUT FETCH cycles halts with a fault.
    applyStimulus(1, 10'h040, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 10'h040, 0, 0, 0, 0, 0, 0);
    fetch_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.halted_o) break;
      if (bus.imem_req_o) fetch_cycles++;
      step();
    end
    checkOutput("to_halted", 32'(bus.halted_o), 1);
    checkOutput("to_fault", 32'(bus.fault_o), 1);
    checkOutput("to_cycles", 32'(fetch_cycles), TIMEOUT);
    applyStimulus(1, 10'h050, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("to_clr_halted", 32'(bus.halted_o), 0);
    checkOutput("to_clr_fault", 32'(bus.fault_o), 0);
    checkOutput("to_refetch", 32'(bus.imem_addr_o), 32'h050);
`else
    fetch_cycles = 0;
`endif

    // Randomized traffic, checked by the every-cycle compare process.
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      applyStimulus(($urandom_range(0, 7) == 0), 10'($urandom), ($urandom_range(0, 2) != 0),
                    8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 15) == 0), 8'($urandom));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
